// File: rtl/dmem_port_arbiter.sv
// Serialises slot-1/slot-2 load/store requests onto a single-ported data memory.
// Program order is kept by always servicing the older slot (slot 1) first.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  input  logic              i_req2,
  input  logic              i_we2,
  input  logic [ADDR_W-1:0] i_addr2,
  input  logic [DATA_W-1:0] i_wdata2,
  output logic              o_ack1,
  output logic              o_ack2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2,
  output logic              o_stall,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [2:0] LatCnt = 3'(MEM_LAT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [2:0]        r_cnt;
  logic [2:0]        w_cnt_d;
  logic              w_grant;
  logic              w_capture;

  // Latched request of the slot currently being serviced
  logic              r_slot2;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              r_mem_en;
  logic              r_mem_we;
  logic              r_ack1;
  logic              r_ack2;
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;

  logic              w_sel2;
  logic              w_we_sel;
  logic [ADDR_W-1:0] w_addr_sel;
  logic [DATA_W-1:0] w_wdata_sel;

  // Slot 1 wins whenever it requests; no round-robin.
  assign w_sel2      = ~i_req1;
  assign w_we_sel    = i_req1 ? i_we1    : i_we2;
  assign w_addr_sel  = i_req1 ? i_addr1  : i_addr2;
  assign w_wdata_sel = i_req1 ? i_wdata1 : i_wdata2;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_grant   = 1'b0;
    w_capture = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_req1 || i_req2) begin
          w_grant   = 1'b1;
          w_state_d = StIssue;
        end
      end
      StIssue: begin
        if (r_we) begin
          w_state_d = StAck;
        end else begin
          w_cnt_d   = LatCnt;
          w_state_d = StWait;
        end
      end
      StWait: begin
        if (r_cnt == 3'd1) begin
          w_capture = 1'b1;
          w_state_d = StAck;
        end else begin
          w_cnt_d = r_cnt - 3'd1;
        end
      end
      StAck: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_slot2  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      r_ack1   <= 1'b0;
      r_ack2   <= 1'b0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
    end else begin
      r_cnt    <= w_cnt_d;
      r_mem_en <= w_grant;
      r_mem_we <= w_grant & w_we_sel;
      // Slot is stable on any transition into StAck, so it decodes the pulse directly
      r_ack1   <= (w_state_d == StAck) && !r_slot2;
      r_ack2   <= (w_state_d == StAck) && r_slot2;
      if (w_grant) begin
        r_slot2 <= w_sel2;
        r_we    <= w_we_sel;
        r_addr  <= w_addr_sel;
        r_wdata <= w_wdata_sel;
      end
      if (w_capture) begin
        if (r_slot2) begin
          r_rdata2 <= i_mem_rdata;
        end else begin
          r_rdata1 <= i_mem_rdata;
        end
      end
    end
  end

  // Address/data stay at the last issued values while the strobe is low
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_ack1      = r_ack1;
  assign o_ack2      = r_ack2;
  assign o_rdata1    = r_rdata1;
  assign o_rdata2    = r_rdata2;
  assign o_stall     = (i_req1 & ~r_ack1) | (i_req2 & ~r_ack2);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: three instances (MEM_LAT 1, 3, 4), each with its own
// behavioural memory; directed table, reset corner case and random pairs vs a reference model.
module tb_dmem_port_arbiter;

  logic       clk = 1'b0;
  logic       reset     [3];
  logic       req1      [3];
  logic       we1       [3];
  logic [7:0] addr1     [3];
  logic [7:0] wdata1    [3];
  logic       req2      [3];
  logic       we2       [3];
  logic [7:0] addr2     [3];
  logic [7:0] wdata2    [3];
  logic       ack1      [3];
  logic       ack2      [3];
  logic [7:0] rdata1    [3];
  logic [7:0] rdata2    [3];
  logic       stall     [3];
  logic       mem_en    [3];
  logic       mem_we    [3];
  logic [7:0] mem_addr  [3];
  logic [7:0] mem_wdata [3];
  logic [7:0] mem_rdata [3];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 4;
  endfunction

  // Power-up memory contents, shared by the memory model and the reference model
  function automatic logic [7:0] init_val(input int k, input logic [7:0] a);
    if (a == 8'h10) return (k == 2) ? 8'hA5 : 8'h5A;
    if (a == 8'h01) return 8'h11;
    if (a == 8'h02) return 8'h22;
    return a ^ 8'(k * 37) ^ 8'h3C;
  endfunction

  // Behavioural memory: writes land at the strobe edge, read data appears
  // only in cycle T+LAT and is poisoned (0xEE) in every other cycle.
  logic [7:0] mem_arr [3][256];
  bit         mem_vld [3][256];
  logic [7:0] pd      [3][4];
  bit         pv      [3][4];

  function automatic logic [7:0] mem_read(input int k, input logic [7:0] a);
    return mem_vld[k][a] ? mem_arr[k][a] : init_val(k, a);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      pd[k][0] <= mem_read(k, mem_addr[k]);
      pv[k][0] <= mem_en[k] && !mem_we[k];
      for (int i = 1; i < 4; i++) begin
        pd[k][i] <= pd[k][i-1];
        pv[k][i] <= pv[k][i-1];
      end
      if (mem_en[k] && mem_we[k]) begin
        mem_arr[k][mem_addr[k]] <= mem_wdata[k];
        mem_vld[k][mem_addr[k]] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    assign mem_rdata[g] = pv[g][L-1] ? pd[g][L-1] : 8'hEE;
    dmem_port_arbiter #(
      .ADDR_W (8),
      .DATA_W (8),
      .MEM_LAT(L)
    ) u_dut (
      .i_clk      (clk),
      .i_reset    (reset[g]),
      .i_req1     (req1[g]),
      .i_we1      (we1[g]),
      .i_addr1    (addr1[g]),
      .i_wdata1   (wdata1[g]),
      .i_req2     (req2[g]),
      .i_we2      (we2[g]),
      .i_addr2    (addr2[g]),
      .i_wdata2   (wdata2[g]),
      .o_ack1     (ack1[g]),
      .o_ack2     (ack2[g]),
      .o_rdata1   (rdata1[g]),
      .o_rdata2   (rdata2[g]),
      .o_stall    (stall[g]),
      .o_mem_en   (mem_en[g]),
      .o_mem_we   (mem_we[g]),
      .o_mem_addr (mem_addr[g]),
      .o_mem_wdata(mem_wdata[g]),
      .i_mem_rdata(mem_rdata[g])
    );
  end

  // Reference model: architectural memory in program order plus expected rdata per slot
  logic [7:0] ref_mem [int];
  logic [7:0] exp_rd1 [3];
  logic [7:0] exp_rd2 [3];

  function automatic logic [7:0] ref_read(input int k, input logic [7:0] a);
    int key = k * 256 + int'(a);
    return ref_mem.exists(key) ? ref_mem[key] : init_val(k, a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Apply one request pair to instance k starting one step after a rising edge,
  // behave as a compliant requester, and check the bus cycle by cycle against a
  // schedule derived from latency arithmetic (write: 2 cycles, read: 2+LAT).
  task automatic run_pair(input int k, input bit r1, input bit w1, input logic [7:0] a1,
                          input logic [7:0] d1, input bit r2, input bit w2,
                          input logic [7:0] a2, input logic [7:0] d2,
                          output int ack1_c, output int ack2_c);
    int L, t1, s2, t2, last, iss1, iss2;
    bit exp_en;
    L    = lat_of(k);
    iss1 = r1 ? 1 : -1;
    t1   = r1 ? (w1 ? 2 : 2 + L) : -1;
    s2   = r1 ? t1 + 1 : 0;
    iss2 = r2 ? s2 + 1 : -1;
    t2   = r2 ? s2 + (w2 ? 2 : 2 + L) : -1;
    last = r2 ? t2 : t1;
    if (r1) begin
      if (w1) ref_mem[k * 256 + int'(a1)] = d1;
      else exp_rd1[k] = ref_read(k, a1);
    end
    if (r2) begin
      if (w2) ref_mem[k * 256 + int'(a2)] = d2;
      else exp_rd2[k] = ref_read(k, a2);
    end
    req1[k] = r1; we1[k] = w1; addr1[k] = a1; wdata1[k] = d1;
    req2[k] = r2; we2[k] = w2; addr2[k] = a2; wdata2[k] = d2;
    ack1_c = -1;
    ack2_c = -1;
    for (int c = 0; c <= last + 2; c++) begin
      bit drop1, drop2;
      @(negedge clk);
      exp_en = (c == iss1) || (c == iss2);
      check($sformatf("k%0d c%0d mem_en", k, c), 32'(mem_en[k]), 32'(exp_en));
      check($sformatf("k%0d c%0d mem_we", k, c), 32'(mem_we[k]),
            32'(exp_en && ((c == iss1) ? w1 : w2)));
      if (exp_en) begin
        check($sformatf("k%0d c%0d mem_addr", k, c), 32'(mem_addr[k]),
              32'((c == iss1) ? a1 : a2));
        if ((c == iss1) ? w1 : w2)
          check($sformatf("k%0d c%0d mem_wdata", k, c), 32'(mem_wdata[k]),
                32'((c == iss1) ? d1 : d2));
      end
      check($sformatf("k%0d c%0d stall", k, c), 32'(stall[k]), 32'(c < last));
      drop1 = ack1[k];
      drop2 = ack2[k];
      if (ack1[k]) ack1_c = (ack1_c < 0) ? c : -2;
      if (ack2[k]) ack2_c = (ack2_c < 0) ? c : -2;
      @(posedge clk);
      #1;
      if (drop1) req1[k] = 1'b0;
      if (drop2) req2[k] = 1'b0;
    end
    req1[k] = 1'b0;
    req2[k] = 1'b0;
    check($sformatf("k%0d ack1 cycle", k), 32'(ack1_c), 32'(t1));
    check($sformatf("k%0d ack2 cycle", k), 32'(ack2_c), 32'(t2));
    check($sformatf("k%0d rdata1", k), 32'(rdata1[k]), 32'(exp_rd1[k]));
    check($sformatf("k%0d rdata2", k), 32'(rdata2[k]), 32'(exp_rd2[k]));
  endtask

  typedef struct {
    int         k;
    bit         r1;
    bit         w1;
    logic [7:0] a1;
    logic [7:0] d1;
    bit         r2;
    bit         w2;
    logic [7:0] a2;
    logic [7:0] d2;
    int         e_ack1;
    int         e_ack2;
    logic [7:0] e_rd1;
    logic [7:0] e_rd2;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #1_000_000;
    $display("FAIL global timeout after %0d compared", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    int a1c, a2c;
    tbl[0] = '{0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 3, -1, 8'h5A, 8'h00};
    tbl[1] = '{0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h33, -1, 2, 8'h5A, 8'h00};
    tbl[2] = '{0, 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 3, 7, 8'h11, 8'h22};
    tbl[3] = '{0, 1, 1, 8'h40, 8'h77, 1, 0, 8'h40, 8'h00, 2, 6, 8'h11, 8'h77};
    tbl[4] = '{2, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 6, -1, 8'hA5, 8'h00};

    for (int k = 0; k < 3; k++) begin
      reset[k] = 1'b1;
      req1[k] = 1'b0; we1[k] = 1'b0; addr1[k] = '0; wdata1[k] = '0;
      req2[k] = 1'b0; we2[k] = 1'b0; addr2[k] = '0; wdata2[k] = '0;
      exp_rd1[k] = '0;
      exp_rd2[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("k%0d reset ack1", k), 32'(ack1[k]), 0);
      check($sformatf("k%0d reset ack2", k), 32'(ack2[k]), 0);
      check($sformatf("k%0d reset mem_en", k), 32'(mem_en[k]), 0);
      check($sformatf("k%0d reset mem_we", k), 32'(mem_we[k]), 0);
      check($sformatf("k%0d reset mem_addr", k), 32'(mem_addr[k]), 0);
      check($sformatf("k%0d reset mem_wdata", k), 32'(mem_wdata[k]), 0);
      check($sformatf("k%0d reset rdata1", k), 32'(rdata1[k]), 0);
      check($sformatf("k%0d reset rdata2", k), 32'(rdata2[k]), 0);
      check($sformatf("k%0d reset stall", k), 32'(stall[k]), 0);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) reset[k] = 1'b0;
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      run_pair(tbl[i].k, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1,
               tbl[i].r2, tbl[i].w2, tbl[i].a2, tbl[i].d2, a1c, a2c);
      check($sformatf("vec%0d ack1 cycle", i), 32'(a1c), 32'(tbl[i].e_ack1));
      check($sformatf("vec%0d ack2 cycle", i), 32'(a2c), 32'(tbl[i].e_ack2));
      check($sformatf("vec%0d rdata1", i), 32'(rdata1[tbl[i].k]), 32'(tbl[i].e_rd1));
      check($sformatf("vec%0d rdata2", i), 32'(rdata2[tbl[i].k]), 32'(tbl[i].e_rd2));
    end

    // Reset in the second WAIT cycle of a MEM_LAT=3 read (ISSUE=1, WAIT=2..4)
    req1[1] = 1'b1; we1[1] = 1'b0; addr1[1] = 8'h01;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset[1] = 1'b1;
    req1[1]  = 1'b0;
    @(posedge clk);
    #1;
    reset[1]   = 1'b0;
    exp_rd1[1] = '0;
    exp_rd2[1] = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("rst c%0d ack1", c), 32'(ack1[1]), 0);
      check($sformatf("rst c%0d mem_en", c), 32'(mem_en[1]), 0);
      check($sformatf("rst c%0d rdata1", c), 32'(rdata1[1]), 0);
    end
    @(posedge clk);
    #1;
    run_pair(1, 1, 0, 8'h02, 8'h00, 0, 0, 8'h00, 8'h00, a1c, a2c);
    check("rst recover ack1 cycle", 32'(a1c), 5);
    check("rst recover rdata1", 32'(rdata1[1]), 32'h22);

    // Random pairs on a small address window so that same-pair hazards are common
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 25; n++) begin
        bit r1, r2;
        r1 = 1'($urandom_range(0, 1));
        r2 = r1 ? 1'($urandom_range(0, 1)) : 1'b1;
        run_pair(k, r1, 1'($urandom_range(0, 1)), 8'h80 + 8'($urandom_range(0, 3)),
                 8'($urandom), r2, 1'($urandom_range(0, 1)),
                 8'h80 + 8'($urandom_range(0, 3)), 8'($urandom), a1c, a2c);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Sequences and arbitrates the single-ported data memory between the two issue slots of the dual-issue 8-bit pipeline. Slot 1 is the older instruction; slot 2 is the younger.
- Accepts load/store requests from the EX/MEM stage of each slot and serialises them in program order.
- Returns load data per slot and holds the pipeline with stall until every request of the current pair has completed.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, data width
MEM_LAT, 1, read latency in cycles from mem_en to valid mem_rdata; legal 1..4; internal counter is 3 bits

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
req1  in  1  slot-1 memory request, level
we1  in  1  slot-1 write (1) / read (0)
addr1  in  ADDR_W  slot-1 address
wdata1  in  DATA_W  slot-1 store data
req2  in  1  slot-2 memory request, level
we2  in  1  slot-2 write/read
addr2  in  ADDR_W  slot-2 address
wdata2  in  DATA_W  slot-2 store data
ack1  out  1  slot-1 completion, one-cycle pulse
ack2  out  1  slot-2 completion, one-cycle pulse
rdata1  out  DATA_W  slot-1 load data, registered
rdata2  out  DATA_W  slot-2 load data, registered
stall  out  1  freeze upstream pipeline stages
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset:
  - state=IDLE; ack1, ack2, mem_en, mem_we = 0; mem_addr, mem_wdata, rdata1, rdata2 = 0.
  - Any in-flight access is abandoned and its mem_rdata is ignored.
  - stall is combinational: (req1 & ~ack1) | (req2 & ~ack2).
- Request protocol:
  - A requester holds req and its fields stable until it sees its ack, then drops req in the following cycle.
  - If req drops before ack, the selected access still completes and ack still pulses. This is not checked.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If req1, select slot 1; else if req2, select slot 2; else stay in IDLE.
  - The selected slot number, we, addr and wdata are latched; next state is ISSUE.
  - Slot 1 always wins when both request, which preserves program order (no round-robin).
- ISSUE (exactly one cycle, cycle T):
  - mem_en=1; mem_we, mem_addr, mem_wdata are driven from the latched fields.
  - Write: next state is ACK.
  - Read: load counter=MEM_LAT; next state is WAIT.
- WAIT:
  - Lasts MEM_LAT cycles (T+1 .. T+MEM_LAT); the counter decrements each cycle; mem_en=0.
  - In the last WAIT cycle, mem_rdata is captured into rdata of the selected slot; next state is ACK.
- ACK:
  - ackN=1 for one cycle; next state is IDLE.
  - IDLE does not sample until the next cycle, so the acked requester has already dropped req and cannot be re-granted.
- Latency from IDLE seeing req:
  - Write: ack at +2 cycles.
  - Read: ack at +3+(MEM_LAT-1) cycles.
- Dual request: slot 1 completes fully before slot 2 is issued. A slot-2 read of an address that slot 1 writes in the same pair returns the new data.
- rdataN holds its value until the next read of that slot; writes do not modify rdataN.
- mem_addr and mem_wdata hold their last driven values while mem_en=0.
- stall deasserts in the ack cycle of the last outstanding request, so the pipeline advances on that edge.
- Reset asserted in any state, including WAIT and ACK: the FSM goes to IDLE on that edge, no ack pulse is produced, and rdata is cleared.

Test Plan:
- Single read, MEM_LAT=1: req1=1, we1=0, addr1=0x10 at cycle 0; memory returns 0x5A at cycle 2. Required: mem_en=1 only in cycle 1, ack1 in cycle 3, rdata1=0x5A, stall=1 in cycles 0-2 and 0 in cycle 3.
- Single write: req2=1, we2=1, addr2=0x20, wdata2=0x33. Required: mem_en=mem_we=1 in cycle 1 with addr 0x20 and data 0x33, ack2 in cycle 2, rdata2 unchanged.
- Dual read, MEM_LAT=1: req1 (addr 0x01) and req2 (addr 0x02) both at cycle 0. Required: slot-1 issue in cycle 1 and ack1 in cycle 3; slot-2 issue in cycle 5 and ack2 in cycle 7; stall high in cycles 0-6.
- Ordering hazard: slot 1 writes 0x77 to 0x40 and slot 2 reads 0x40 in the same cycle, with a behavioural memory model. Required: write issued first, then rdata2=0x77.
- Latency sweep, MEM_LAT=4: single read at cycle 0. Required: ISSUE in cycle 1, WAIT in cycles 2-5, capture in cycle 5, ack in cycle 6.
- Reset mid-operation: assert reset in the second WAIT cycle of a MEM_LAT=3 read. Required: no ack, rdata1=0, state IDLE; a new req1 afterwards is serviced normally.
